// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Multiply/divide unit with the architectural HI/LO registers for the
// Minisys-1A execute stage. Multiplies finish after MUL_STAGES cycles.
// Divides use an iterative radix-2 restoring divider that produces one
// quotient bit per cycle. A start/busy/done handshake lets the hazard unit
// stall mfhi/mflo until HI/LO hold the new result.
//
// Optional build macro:
//   DIV_EARLY_EXIT_EN - when defined, a divide whose dividend magnitude is
//                       below the divisor magnitude skips the iterations and
//                       finishes after two cycles.
//
// Parameters:
//   WIDTH       operand width; HI and LO are each WIDTH bits
//   MUL_STAGES  multiply latency in cycles (minimum 1)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        request, sampled only while idle
//   op           000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   operand_a    rs: dividend or multiplicand
//   operand_b    rt: divisor or multiplier
//   flush        cancels the in-flight operation, or a same-cycle start
//   busy         an operation is in flight
//   done         one-cycle pulse; HI/LO hold the result in this cycle
//   divide_zero  pulses together with done for a divide by zero
//   hi, lo       HI and LO registers
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divide_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done, r_divZero;
  logic [31:0]          r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_rem, r_quot, r_dvs;
  logic                 r_negQ, r_negR;

  logic                 w_accept, w_isMul, w_isDiv, w_opSigned;
  logic                 w_aNeg, w_bNeg;
  logic [WIDTH-1:0]     w_aMag, w_bMag;
  logic [2*WIDTH-1:0]   w_prodMag, w_prod;
  logic                 w_loadMul, w_writeMulNow, w_writeMulReg;
  logic                 w_loadDiv, w_early, w_divIter, w_fixWrite;
  logic                 w_writeHi, w_writeLo, w_divZero;

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and keep the subtraction only if it did not borrow.
  // Returns {new remainder, new quotient/dividend shift register}.
  function automatic logic [2*WIDTH-1:0] divStep(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quot,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {rem, quot[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    if (!diff[WIDTH])
      divStep = {diff[WIDTH-1:0], quot[WIDTH-2:0], 1'b1};
    else
      divStep = {sh[WIDTH-1:0], quot[WIDTH-2:0], 1'b0};
  endfunction

  assign w_isMul    = (op == 3'b000) || (op == 3'b001);
  assign w_isDiv    = (op == 3'b010) || (op == 3'b011);
  assign w_opSigned = ~op[0];
  assign w_accept   = start && !flush && (r_state == IDLE);

  // Signed operations work on magnitudes; the sign is re-applied at the end.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude.
  assign w_aNeg    = w_opSigned & operand_a[WIDTH-1];
  assign w_bNeg    = w_opSigned & operand_b[WIDTH-1];
  assign w_aMag    = w_aNeg ? (~operand_a + 1'b1) : operand_a;
  assign w_bMag    = w_bNeg ? (~operand_b + 1'b1) : operand_b;
  assign w_prodMag = {{WIDTH{1'b0}}, w_aMag} * {{WIDTH{1'b0}}, w_bMag};
  assign w_prod    = (w_aNeg ^ w_bNeg) ? (~w_prodMag + 1'b1) : w_prodMag;

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign divide_zero = r_divZero;
  assign hi          = r_hi;
  assign lo          = r_lo;

  // State register. Reset abandons whatever was in flight.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and control strobes. Flush drops any in-flight work back to
  // IDLE without writing HI/LO; a single-stage multiply writes straight from
  // IDLE, and a zero divisor answers immediately without entering DIV.
  always_comb begin
    w_next        = r_state;
    w_loadMul     = 1'b0;
    w_writeMulNow = 1'b0;
    w_writeMulReg = 1'b0;
    w_loadDiv     = 1'b0;
    w_early       = 1'b0;
    w_divIter     = 1'b0;
    w_fixWrite    = 1'b0;
    w_writeHi     = 1'b0;
    w_writeLo     = 1'b0;
    w_divZero     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isMul) begin
            if (MUL_STAGES == 1) begin
              w_writeMulNow = 1'b1;
            end else begin
              w_loadMul = 1'b1;
              w_next    = MUL;
            end
          end else if (w_isDiv) begin
            if (operand_b == '0) begin
              w_divZero = 1'b1;
`ifdef DIV_EARLY_EXIT_EN
            end else if (w_aMag < w_bMag) begin
              w_early = 1'b1;
              w_next  = FIX;
`endif
            end else begin
              w_loadDiv = 1'b1;
              w_next    = DIV;
            end
          end else if (op == 3'b100) begin
            w_writeHi = 1'b1;
          end else if (op == 3'b101) begin
            w_writeLo = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          w_next = IDLE;
        end else if (r_cnt == '0) begin
          w_writeMulReg = 1'b1;
          w_next        = IDLE;
        end
      end
      DIV: begin
        if (flush) begin
          w_next = IDLE;
        end else begin
          w_divIter = 1'b1;
          if (r_cnt == '0) w_next = FIX;
        end
      end
      FIX: begin
        w_next = IDLE;
        if (!flush) w_fixWrite = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath. The first divide iteration runs while the operands are being
  // latched, so WIDTH-1 further cycles in DIV complete all WIDTH quotient
  // bits and FIX still lands the result WIDTH+1 cycles after start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_dvs     <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
    end else begin
      r_done    <= w_writeMulNow | w_writeMulReg | w_writeHi | w_writeLo |
                   w_fixWrite | w_divZero;
      r_divZero <= w_divZero;

      if (w_loadMul)
        r_cnt <= 32'(MUL_STAGES - 2);
      else if (w_loadDiv)
        r_cnt <= 32'(WIDTH - 2);
      else if ((r_state == MUL || r_state == DIV) && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;

      if (w_loadMul) r_prod <= w_prod;

      if (w_loadDiv || w_early) begin
        r_dvs  <= w_bMag;
        r_negQ <= w_aNeg ^ w_bNeg;
        r_negR <= w_aNeg;
      end
      if (w_loadDiv)
        {r_rem, r_quot} <= divStep('0, w_aMag, w_bMag);
      else if (w_early)
        {r_rem, r_quot} <= {w_aMag, {WIDTH{1'b0}}};
      else if (w_divIter)
        {r_rem, r_quot} <= divStep(r_rem, r_quot, r_dvs);

      if (w_writeMulNow) begin
        {r_hi, r_lo} <= w_prod;
      end else if (w_writeMulReg) begin
        {r_hi, r_lo} <= r_prod;
      end else if (w_fixWrite) begin
        r_lo <= r_negQ ? (~r_quot + 1'b1) : r_quot;
        r_hi <= r_negR ? (~r_rem + 1'b1) : r_rem;
      end else if (w_writeHi) begin
        r_hi <= operand_a;
      end else if (w_writeLo) begin
        r_lo <= operand_a;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit (WIDTH = 32, MUL_STAGES = 2). The
// reference model computes HI/LO with 64-bit integer arithmetic and derives
// the expected latency from the operation type.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clock;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          flush;
  logic          busy;
  logic          done;
  logic          divide_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int            errors;
  int            checks;
  logic [W-1:0]  mHi;
  logic [W-1:0]  mLo;

  mul_div_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .divide_zero (divide_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: counts it, and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Presents a request for cycle 0, steps into cycle 1, then scrambles the
  // operand lines so that any use of unlatched operands shows up.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(negedge clock);
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Reference model: architectural results from plain integer arithmetic.
  task automatic refModel(input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic dz,
                          output int n);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    n  = 1;
    case (o)
      3'd0: begin
        sp = sa * sb;
        {mHi, mLo} = sp;
        n = MS;
      end
      3'd1: begin
        up = ua * ub;
        {mHi, mLo} = up;
        n = MS;
      end
      3'd2, 3'd3: begin
        if (b == '0) begin
          dz = 1'b1;
        end else begin
          if (o == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            if (sa < 0) sa = -sa;
            if (sb < 0) sb = -sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            sa = longint'(ua);
            sb = longint'(ub);
          end
          mLo = q[31:0];
          mHi = r[31:0];
          n = W + 1;
`ifdef DIV_EARLY_EXIT_EN
          if (sa < sb) n = 2;
`endif
        end
      end
      3'd4: mHi = a;
      3'd5: mLo = a;
      default: n = 0;
    endcase
  endtask

  // Runs one operation to completion and checks latency, busy, HI/LO and
  // divide_zero against the model; also checks done is a single pulse.
  task automatic runOp(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    logic eDz;
    int   eN;
    int   n;
    refModel(o, a, b, eDz, eN);
    applyStimulus(o, a, b);
    n = 1;
    if (eN > 1) checkOutput({tag, " busy@1"}, 64'(busy), 64'd1);
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'(eN));
    checkOutput({tag, " busy@N"}, 64'(busy), 64'd0);
    checkOutput({tag, " hi"}, 64'(hi), 64'(mHi));
    checkOutput({tag, " lo"}, 64'(lo), 64'(mLo));
    checkOutput({tag, " divzero"}, 64'(divide_zero), 64'(eDz));
    @(negedge clock);
    checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin : stimulus
    int          n;
    logic        sawDone;
    logic [2:0]  rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    errors    = 0;
    checks    = 0;
    mHi       = '0;
    mLo       = '0;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    op        = 3'd0;
    operand_a = '0;
    operand_b = '0;
    repeat (3) @(negedge clock);

    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset divzero", 64'(divide_zero), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases.
    runOp(3'd0, 32'hFFFFFFFD, 32'd5, "mult -3*5");
    runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
    runOp(3'd2, 32'hFFFFFFF9, 32'd2, "div -7/2");
    runOp(3'd3, 32'd100, 32'd7, "divu 100/7");
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
    runOp(3'd4, 32'h12345678, 32'd0, "mthi");
    runOp(3'd5, 32'h12345678, 32'd0, "mtlo");
    runOp(3'd3, 32'd5, 32'd0, "divu by zero");
    runOp(3'd3, 32'd3, 32'd10, "divu 3/10");
    runOp(3'd2, 32'hFFFFFFFD, 32'd10, "div -3/10");

    // Flush during a divide in cycle 10: idle next cycle, no result ever.
    applyStimulus(3'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) sawDone = 1'b1;
      @(negedge clock);
    end
    checkOutput("flush no done", 64'(sawDone), 64'd0);
    checkOutput("flush hi", 64'(hi), 64'(mHi));
    checkOutput("flush lo", 64'(lo), 64'(mLo));
    runOp(3'd4, 32'hCAFEBABE, 32'd0, "mthi after flush");

    // Flush together with start suppresses the start.
    start     = 1'b1;
    flush     = 1'b1;
    op        = 3'd5;
    operand_a = 32'h0BADF00D;
    @(negedge clock);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush+start done", 64'(done), 64'd0);
    checkOutput("flush+start lo", 64'(lo), 64'(mLo));

    // Illegal op code: no done, no change.
    start = 1'b1;
    op    = 3'd7;
    @(negedge clock);
    start = 1'b0;
    checkOutput("illegal done", 64'(done), 64'd0);
    checkOutput("illegal busy", 64'(busy), 64'd0);
    checkOutput("illegal hi", 64'(hi), 64'(mHi));

    // Start while busy is ignored; a start in the done cycle is accepted.
    refModel(3'd0, 32'd7, 32'd6, sawDone, n);
    applyStimulus(3'd0, 32'd7, 32'd6);
    start     = 1'b1;
    op        = 3'd3;
    operand_a = 32'd100;
    operand_b = 32'd7;
    @(negedge clock);
    checkOutput("b2b mult done", 64'(done), 64'd1);
    checkOutput("b2b mult lo", 64'(lo), 64'(mLo));
    checkOutput("b2b mult hi", 64'(hi), 64'(mHi));
    refModel(3'd3, 32'd100, 32'd7, sawDone, n);
    @(negedge clock);
    start = 1'b0;
    checkOutput("b2b divu busy", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("b2b divu latency", 64'(n), 64'(W + 1));
    checkOutput("b2b divu lo", 64'(lo), 64'(mLo));
    checkOutput("b2b divu hi", 64'(hi), 64'(mHi));
    @(negedge clock);

    // Reset mid-divide clears the unit including HI/LO.
    applyStimulus(3'd3, 32'd999, 32'd4);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mHi = '0;
    mLo = '0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset hi", 64'(hi), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) sawDone = 1'b1;
      @(negedge clock);
    end
    checkOutput("midreset no done", 64'(sawDone), 64'd0);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 20));
      runOp(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
